// File: rtl/fermat_mod_reduce_if.sv
// Streaming operand/result bundle for the Fermat-prime reducer.
// The master drives operands in and receives residues back; the slave is the reducer.
interface fermat_mod_reduce_if #(
   parameter int WIDTH = 18
);
   logic                      in_valid;
   logic signed [2*WIDTH-1:0] input_mod;
   logic                      out_valid;
   logic [WIDTH-1:0]          output_mod;

   modport master (
      output in_valid,
      output input_mod,
      input  out_valid,
      input  output_mod
   );

   modport slave (
      input  in_valid,
      input  input_mod,
      output out_valid,
      output output_mod
   );
endinterface

// File: rtl/fermat_mod_reduce.sv
// Two-stage pipelined reducer: signed 2*WIDTH-bit operand -> residue mod P = 2^m + 1.
// Stage 1 folds the operand into an alternating chunk sum (2^m == -1 mod P).
// Stage 2 pulls that sum back into [0, P-1] and registers it zero-extended.
module fermat_mod_reduce #(
   parameter int WIDTH = 18,
   parameter int m     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fermat_mod_reduce_if.slave bus
);
   localparam int IW    = 2 * WIDTH;
   // number of m-bit chunks; the last one holds the sign-extended leftover bits
   localparam int NC    = (IW + m - 1) / m;
   // alternating sum magnitude stays below about ceil(NC/2) * 2^m, plus sign
   localparam int ACC_W = m + $clog2(NC) + 2;
   localparam int EXT_W = (IW > ACC_W) ? IW : ACC_W;

   localparam logic signed [ACC_W-1:0] ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
   localparam logic signed [ACC_W-1:0] MODP = (ONE <<< m) + ONE;

   // Alternating sum c0 - c1 + c2 - ... with only the top chunk treated as signed.
   function automatic logic signed [ACC_W-1:0] alt_sum(input logic signed [IW-1:0] x);
      logic signed [EXT_W-1:0] xe;
      logic signed [ACC_W-1:0] chunk;
      logic signed [ACC_W-1:0] acc;
      xe    = EXT_W'(x);
      acc   = '0;
      chunk = '0;
      for (int i = 0; i < NC; i++) begin
         if (i == NC - 1) begin
            chunk = ACC_W'(xe >>> ((NC - 1) * m));
         end else begin
            chunk = ACC_W'(xe[i*m +: m]);
         end
         if (i[0] == 1'b0) begin
            acc = acc + chunk;
         end else begin
            acc = acc - chunk;
         end
      end
      return acc;
   endfunction

   // Range correction. At the default sizes the sum can reach -(P + 6), so one
   // add of P is not always enough; NC conditional steps cover every legal setting.
   function automatic logic [m:0] fold(input logic signed [ACC_W-1:0] s);
      logic signed [ACC_W-1:0] r;
      r = s;
      for (int i = 0; i < NC; i++) begin
         if (r[ACC_W-1] == 1'b1) begin
            r = r + MODP;
         end else if (r >= MODP) begin
            r = r - MODP;
         end else begin
            r = r;
         end
      end
      return r[m:0];
   endfunction

   logic signed [ACC_W-1:0] sum_s;
   logic [m:0]              res_s;
   logic signed [ACC_W-1:0] s1_sum_r;
   logic                    s1_valid_r;
   logic [WIDTH-1:0]        out_mod_r;
   logic                    out_valid_r;

   // Stage 1 combinational fold of the incoming operand.
   always_comb begin
      sum_s = alt_sum(bus.input_mod);
   end

   // Stage 2 combinational range correction of the registered sum.
   always_comb begin
      res_s = fold(s1_sum_r);
   end

   // Stage 1 register: chunk sum and its valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum_r   <= '0;
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum_r <= sum_s;
         end
      end
   end

   // Stage 2 register: residue held between valid results, bubbles pass through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_mod_r   <= '0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_mod_r <= WIDTH'(res_s);
         end
      end
   end

   assign bus.output_mod = out_mod_r;
   assign bus.out_valid  = out_valid_r;
endmodule

// File: tb/tb_fermat_mod_reduce.sv
// Directed bench for fermat_mod_reduce at WIDTH=18, m=16 (P = 65537).
// Each step drives one operand and checks what left the pipe two clocks earlier.
module tb_fermat_mod_reduce;
   logic clk;
   logic rst_n;

   fermat_mod_reduce_if #(.WIDTH(18)) bus ();

   fermat_mod_reduce #(.WIDTH(18), .m(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors;
   int miscompares;

   // expected-output pipeline: slot 1 = just captured, slot 2 = due at output now
   logic        ev1, ev2;
   logic [17:0] ed1, ed2;
   string       et1, et2;

   // free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic v, input logic signed [35:0] d,
                       input logic [17:0] e);
      bus.in_valid  = v;
      bus.input_mod = d;
      @(posedge clk);
      #1;
      ev2 = ev1;
      ed2 = ed1;
      et2 = et1;
      ev1 = v;
      ed1 = e;
      et1 = tag;
      check_val({et2, "_valid"}, 64'(bus.out_valid), 64'(ev2));
      if (ev2) begin
         check_val(et2, 64'(bus.output_mod), 64'(ed2));
      end
   endtask

   task automatic clear_model();
      ev1 = 1'b0;
      ev2 = 1'b0;
      ed1 = 18'd0;
      ed2 = 18'd0;
      et1 = "idle";
      et2 = "idle";
   endtask

   // directed sequence
   initial begin
      logic signed [35:0] r;
      longint             xl;
      longint             ex;

      vectors     = 0;
      miscompares = 0;
      clear_model();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.input_mod = 36'sd0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("reset_output_mod", 64'(bus.output_mod), 64'd0);
      rst_n = 1'b1;

      // basic: zero
      step("zero", 1'b1, 36'sd0, 18'd0);
      step("idle", 1'b0, 36'sd0, 18'd0);
      step("idle", 1'b0, 36'sd0, 18'd0);

      // back-to-back positives, negatives, extremes and boundaries
      step("p65537",  1'b1, 36'sd65537,  18'd0);
      step("p65540",  1'b1, 36'sd65540,  18'd3);
      step("p123085", 1'b1, 36'sd123085, 18'd57548);
      step("n1",      1'b1, -36'sd1,     18'd65536);
      step("n48577",  1'b1, -36'sd48577, 18'd16960);
      step("most_neg", 1'b1, 36'h8_0000_0000, 18'd65529);
      step("most_pos", 1'b1, 36'h7_FFFF_FFFF, 18'd7);
      step("p65536",  1'b1, 36'sd65536,  18'd65536);
      // alternating sum reaches -(P+6): needs a second correction step
      step("deep_neg", 1'b1, 36'h8_FFFF_0000, 18'd65531);
      step("p65538",  1'b1, 36'sd65538,  18'd1);
      step("idle", 1'b0, 36'sd0, 18'd0);
      step("idle", 1'b0, 36'sd0, 18'd0);

      // bubbles: alternate valid / idle
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            step("bubble_v", 1'b1, 36'(i + 65537), 18'(i));
         end else begin
            step("bubble_i", 1'b0, 36'sd99, 18'd0);
         end
      end
      step("idle", 1'b0, 36'sd0, 18'd0);
      step("idle", 1'b0, 36'sd0, 18'd0);

      // reset with operands in flight: one in stage 1, one at the input
      step("pre_rst", 1'b1, 36'sd5, 18'd5);
      bus.in_valid  = 1'b1;
      bus.input_mod = 36'sd7;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_async_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_async_mod", 64'(bus.output_mod), 64'd0);
      @(posedge clk);
      #1;
      check_val("rst_held_valid", 64'(bus.out_valid), 64'd0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      step("post_rst", 1'b0, 36'sd0, 18'd0);
      step("post_rst", 1'b0, 36'sd0, 18'd0);
      step("post_rst", 1'b0, 36'sd0, 18'd0);

      // random operands against a floored-mod reference
      for (int i = 0; i < 300; i++) begin
         r  = 36'({$urandom(), $urandom()});
         xl = r;
         ex = xl % 64'sd65537;
         if (ex < 64'sd0) begin
            ex = ex + 64'sd65537;
         end
         step("rand", 1'b1, r, 18'(ex));
      end
      step("idle", 1'b0, 36'sd0, 18'd0);
      step("idle", 1'b0, 36'sd0, 18'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
